// File: rtl/battle_front_scan_pkg.sv
// Shared types and constants for the battle front scanner.
package battle_front_scan_pkg;

   localparam int LOC_W_DEF  = 9;
   localparam int TYPE_EMPTY = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2,
      DONE   = 2'd3
   } scan_state_e;

   typedef enum logic {
      DIR_MIN = 1'b0,
      DIR_MAX = 1'b1
   } accum_dir_e;

   // Index reported when a side has no live unit in a lane.
   function automatic int selSentinel(input int nUnits);
      return nUnits;
   endfunction

endpackage

// File: rtl/battle_front_scan_if.sv
// Start/ack handshake, unit-state inputs and per-lane front results.
interface battle_front_scan_if #(
   parameter int N_LANES = 1,
   parameter int N_UNITS = 16,
   parameter int LOC_W   = 9,
   parameter int TYPE_W  = 2
);
   localparam int SEL_W = $clog2(N_UNITS) + 1;

   logic                              start;
   logic                              ack;
   logic [N_LANES*N_UNITS*LOC_W-1:0]  unit_loc;
   logic [N_LANES*N_UNITS*TYPE_W-1:0] unit_type;
   logic [N_LANES*N_UNITS*LOC_W-1:0]  enemy_loc;
   logic [N_LANES*N_UNITS*TYPE_W-1:0] enemy_type;
   logic [N_LANES*LOC_W-1:0]          friendly_front;
   logic [N_LANES*LOC_W-1:0]          enemy_front;
   logic [N_LANES*SEL_W-1:0]          unit_sel;
   logic [N_LANES*SEL_W-1:0]          enemy_sel;
   logic [N_LANES-1:0]                contact;
   logic                              busy;
   logic                              done;

   modport master (
      output start, ack, unit_loc, unit_type, enemy_loc, enemy_type,
      input  friendly_front, enemy_front, unit_sel, enemy_sel, contact, busy, done
   );

   modport slave (
      input  start, ack, unit_loc, unit_type, enemy_loc, enemy_type,
      output friendly_front, enemy_front, unit_sel, enemy_sel, contact, busy, done
   );

endinterface

// File: rtl/battle_front_scan_accum.sv
// Running min (friendly) or max (enemy) of offset unit locations within one lane.
// res* include the unit presented this cycle, so the lane result is usable at its last unit.
module battle_front_scan_accum
   import battle_front_scan_pkg::*;
#(
   parameter accum_dir_e DIR     = DIR_MIN,
   parameter int         LOC_W   = LOC_W_DEF,
   parameter int         SEL_W   = 5,
   parameter int         OFS     = 6,
   parameter int         N_UNITS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             step,
   input  logic             live,
   input  logic [LOC_W-1:0] loc,
   input  logic [SEL_W-1:0] idx,
   output logic [LOC_W-1:0] resLoc,
   output logic [SEL_W-1:0] resSel,
   output logic             resLive
);

   localparam logic [LOC_W:0]   LOC_MAX_X = {1'b0, {LOC_W{1'b1}}};
   localparam logic [LOC_W:0]   OFS_X     = (LOC_W+1)'(OFS);
   localparam logic [LOC_W-1:0] INIT_LOC  = (DIR == DIR_MIN) ? {LOC_W{1'b1}} : '0;
   localparam logic [SEL_W-1:0] SEL_NONE  = SEL_W'(selSentinel(N_UNITS));

   logic [LOC_W-1:0] bestLoc;
   logic [SEL_W-1:0] bestSel;
   logic             bestLive;

   logic [LOC_W:0]   locX;
   logic [LOC_W:0]   adjX;
   logic [LOC_W-1:0] adj;
   logic [LOC_W-1:0] curLoc;
   logic [SEL_W-1:0] curSel;
   logic             curLive;
   logic             better;

   always_comb begin
      locX = {1'b0, loc};
      adjX = '0;
      // One extra bit keeps the offset from wrapping before it is clamped.
      if (DIR == DIR_MIN) begin
         adjX = (locX < OFS_X) ? '0 : (locX - OFS_X);
      end else begin
         adjX = locX + OFS_X;
         if (adjX > LOC_MAX_X) adjX = LOC_MAX_X;
      end
      adj = adjX[LOC_W-1:0];

      curLoc  = init ? INIT_LOC : bestLoc;
      curSel  = init ? SEL_NONE : bestSel;
      curLive = init ? 1'b0     : bestLive;

      // Strict compare: on a tie the earlier (lower) index keeps the front.
      better = (DIR == DIR_MIN) ? (adj < curLoc) : (adj > curLoc);

      resLoc  = curLoc;
      resSel  = curSel;
      resLive = curLive;
      if (live && (!curLive || better)) begin
         resLoc  = adj;
         resSel  = idx;
         resLive = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bestLoc  <= INIT_LOC;
         bestSel  <= SEL_NONE;
         bestLive <= 1'b0;
      end else if (step) begin
         bestLoc  <= resLoc;
         bestSel  <= resSel;
         bestLive <= resLive;
      end
   end

endmodule

// File: rtl/battle_front_scan.sv
// Serial per-lane scan of friendly/enemy unit fronts with start/done/ack handshake.
//   state  | meaning
//   IDLE   | waiting for start; outputs hold the last committed results
//   SCAN   | one friendly/enemy unit pair per cycle, lane-major
//   COMMIT | staging copied to outputs
//   DONE   | results valid, waiting for ack
module battle_front_scan
   import battle_front_scan_pkg::*;
#(
   parameter int N_LANES = 1,
   parameter int N_UNITS = 16,
   parameter int LOC_W   = LOC_W_DEF,
   parameter int TYPE_W  = 2,
   parameter int OFS_F   = 6,
   parameter int OFS_E   = 7
) (
   input logic                clk,
   input logic                rst,
   battle_front_scan_if.slave bus
);

   localparam int SEL_W   = $clog2(N_UNITS) + 1;
   localparam int UNIT_W  = $clog2(N_UNITS);
   localparam int LANE_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam int NB_LOC  = N_LANES * N_UNITS * LOC_W;
   localparam int NB_TYPE = N_LANES * N_UNITS * TYPE_W;
   localparam int NB_LF   = N_LANES * LOC_W;
   localparam int NB_LS   = N_LANES * SEL_W;

   localparam logic [LOC_W-1:0] LOC_MAX  = {LOC_W{1'b1}};
   localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(selSentinel(N_UNITS));

   scan_state_e state, nextState;

   logic [UNIT_W-1:0]  unitIdx;
   logic [LANE_W-1:0]  laneIdx;
   logic [NB_LOC-1:0]  snapFLoc, snapELoc;
   logic [NB_TYPE-1:0] snapFType, snapEType;

   logic [NB_LF-1:0]   stageFF, stageEF, outFF, outEF;
   logic [NB_LS-1:0]   stageFS, stageES, outFS, outES;
   logic [N_LANES-1:0] stageC, outC;

   int               flat;
   logic [LOC_W-1:0] fLoc, eLoc;
   logic             fLive, eLive;
   logic             lastUnit, lastLane, laneInit, scanStep;

   logic [LOC_W-1:0] resLocF, resLocE;
   logic [SEL_W-1:0] resSelF, resSelE;
   logic             resLiveF, resLiveE;

   always_comb begin
      flat     = int'(laneIdx) * N_UNITS + int'(unitIdx);
      fLoc     = snapFLoc[flat*LOC_W +: LOC_W];
      eLoc     = snapELoc[flat*LOC_W +: LOC_W];
      fLive    = snapFType[flat*TYPE_W +: TYPE_W] != TYPE_W'(TYPE_EMPTY);
      eLive    = snapEType[flat*TYPE_W +: TYPE_W] != TYPE_W'(TYPE_EMPTY);
      lastUnit = unitIdx == UNIT_W'(N_UNITS - 1);
      lastLane = laneIdx == LANE_W'(N_LANES - 1);
      laneInit = unitIdx == '0;
      scanStep = state == SCAN;
   end

   battle_front_scan_accum #(
      .DIR(DIR_MIN), .LOC_W(LOC_W), .SEL_W(SEL_W), .OFS(OFS_F), .N_UNITS(N_UNITS)
   ) u_accF (
      .clk(clk), .rst(rst), .init(laneInit), .step(scanStep), .live(fLive),
      .loc(fLoc), .idx(SEL_W'(unitIdx)),
      .resLoc(resLocF), .resSel(resSelF), .resLive(resLiveF)
   );

   battle_front_scan_accum #(
      .DIR(DIR_MAX), .LOC_W(LOC_W), .SEL_W(SEL_W), .OFS(OFS_E), .N_UNITS(N_UNITS)
   ) u_accE (
      .clk(clk), .rst(rst), .init(laneInit), .step(scanStep), .live(eLive),
      .loc(eLoc), .idx(SEL_W'(unitIdx)),
      .resLoc(resLocE), .resSel(resSelE), .resLive(resLiveE)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // ack has priority in DONE simply because start is only looked at in IDLE.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (bus.start) nextState = SCAN;
         SCAN:    if (lastUnit && lastLane) nextState = COMMIT;
         COMMIT:  nextState = DONE;
         DONE:    if (bus.ack) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         unitIdx   <= '0;
         laneIdx   <= '0;
         snapFLoc  <= '0;
         snapELoc  <= '0;
         snapFType <= '0;
         snapEType <= '0;
         stageFF   <= {N_LANES{LOC_MAX}};
         stageEF   <= '0;
         stageFS   <= {N_LANES{SEL_NONE}};
         stageES   <= {N_LANES{SEL_NONE}};
         stageC    <= '0;
         outFF     <= {N_LANES{LOC_MAX}};
         outEF     <= '0;
         outFS     <= {N_LANES{SEL_NONE}};
         outES     <= {N_LANES{SEL_NONE}};
         outC      <= '0;
      end else begin
         if (state == IDLE && bus.start) begin
            snapFLoc  <= bus.unit_loc;
            snapELoc  <= bus.enemy_loc;
            snapFType <= bus.unit_type;
            snapEType <= bus.enemy_type;
            unitIdx   <= '0;
            laneIdx   <= '0;
         end
         if (state == SCAN) begin
            if (lastUnit) begin
               unitIdx <= '0;
               laneIdx <= lastLane ? '0 : laneIdx + 1'b1;
               for (int l = 0; l < N_LANES; l++) begin
                  if (laneIdx == LANE_W'(l)) begin
                     stageFF[l*LOC_W +: LOC_W] <= resLocF;
                     stageEF[l*LOC_W +: LOC_W] <= resLocE;
                     stageFS[l*SEL_W +: SEL_W] <= resSelF;
                     stageES[l*SEL_W +: SEL_W] <= resSelE;
                     stageC[l]                 <= resLiveF && resLiveE && (resLocF <= resLocE);
                  end
               end
            end else begin
               unitIdx <= unitIdx + 1'b1;
            end
         end
         if (state == COMMIT) begin
            outFF <= stageFF;
            outEF <= stageEF;
            outFS <= stageFS;
            outES <= stageES;
            outC  <= stageC;
         end
      end
   end

   assign bus.friendly_front = outFF;
   assign bus.enemy_front    = outEF;
   assign bus.unit_sel       = outFS;
   assign bus.enemy_sel      = outES;
   assign bus.contact        = outC;
   assign bus.busy           = state != IDLE;
   assign bus.done           = state == DONE;

endmodule

// File: tb/tb_battle_front_scan.sv
// Bench for battle_front_scan: directed table, handshake corner cases, randomized model compare.
module tb_battle_front_scan;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   battle_front_scan_if #(.N_LANES(1), .N_UNITS(16), .LOC_W(9), .TYPE_W(2)) ifA ();
   battle_front_scan_if #(.N_LANES(2), .N_UNITS(4),  .LOC_W(9), .TYPE_W(2)) ifB ();

   battle_front_scan #(.N_LANES(1), .N_UNITS(16)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
   battle_front_scan #(.N_LANES(2), .N_UNITS(4))  dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

   typedef struct {
      int fi0, fl0, ft0, fi1, fl1, ft1;
      int ei0, el0, et0, ei1, el1, et1;
      int expFF, expEF, expFS, expES, expC;
   } vec_t;

   vec_t vecs[9];
   int   total = 0;
   int   bad   = 0;
   int   fL[16], fT[16], eL[16], eT[16];
   int   picks[8] = '{0, 5, 6, 7, 504, 505, 511, 64};

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clearUnits();
      for (int i = 0; i < 16; i++) begin
         fL[i] = 5; fT[i] = 0; eL[i] = 500; eT[i] = 0;
      end
   endtask

   task automatic driveInputs(input int which);
      if (which == 0) begin
         for (int u = 0; u < 16; u++) begin
            ifA.unit_loc[u*9 +: 9]   = 9'(fL[u]);
            ifA.unit_type[u*2 +: 2]  = 2'(fT[u]);
            ifA.enemy_loc[u*9 +: 9]  = 9'(eL[u]);
            ifA.enemy_type[u*2 +: 2] = 2'(eT[u]);
         end
      end else begin
         for (int u = 0; u < 8; u++) begin
            ifB.unit_loc[u*9 +: 9]   = 9'(fL[u]);
            ifB.unit_type[u*2 +: 2]  = 2'(fT[u]);
            ifB.enemy_loc[u*9 +: 9]  = 9'(eL[u]);
            ifB.enemy_type[u*2 +: 2] = 2'(eT[u]);
         end
      end
   endtask

   task automatic scramble();
      for (int u = 0; u < 16; u++) begin
         ifA.unit_loc[u*9 +: 9]   = 9'($urandom);
         ifA.unit_type[u*2 +: 2]  = 2'($urandom);
         ifA.enemy_loc[u*9 +: 9]  = 9'($urandom);
         ifA.enemy_type[u*2 +: 2] = 2'($urandom);
      end
      for (int u = 0; u < 8; u++) begin
         ifB.unit_loc[u*9 +: 9]   = 9'($urandom);
         ifB.unit_type[u*2 +: 2]  = 2'($urandom);
         ifB.enemy_loc[u*9 +: 9]  = 9'($urandom);
         ifB.enemy_type[u*2 +: 2] = 2'($urandom);
      end
   endtask

   // Reference: fronts straight from the unit arrays with plain integer arithmetic.
   task automatic modelLane(input int base, input int nU,
                            output int ff, output int ef, output int fs, output int es,
                            output int ct);
      bit fAny = 0, eAny = 0;
      int v;
      ff = 511; ef = 0; fs = nU; es = nU;
      for (int u = 0; u < nU; u++) begin
         if (fT[base+u] != 0) begin
            v = fL[base+u] - 6;
            if (v < 0) v = 0;
            if (!fAny || v < ff) begin ff = v; fs = u; end
            fAny = 1;
         end
         if (eT[base+u] != 0) begin
            v = eL[base+u] + 7;
            if (v > 511) v = 511;
            if (!eAny || v > ef) begin ef = v; es = u; end
            eAny = 1;
         end
      end
      ct = (fAny && eAny && ff <= ef) ? 1 : 0;
   endtask

   function automatic int getOut(input int which, input int lane, input int field);
      if (which == 0) begin
         case (field)
            0: return int'(ifA.friendly_front);
            1: return int'(ifA.enemy_front);
            2: return int'(ifA.unit_sel);
            3: return int'(ifA.enemy_sel);
            default: return int'(ifA.contact);
         endcase
      end else begin
         case (field)
            0: return int'(ifB.friendly_front[lane*9 +: 9]);
            1: return int'(ifB.enemy_front[lane*9 +: 9]);
            2: return int'(ifB.unit_sel[lane*3 +: 3]);
            3: return int'(ifB.enemy_sel[lane*3 +: 3]);
            default: return int'(ifB.contact[lane]);
         endcase
      end
   endfunction

   function automatic bit doneOf(input int which);
      return (which == 0) ? ifA.done : ifB.done;
   endfunction

   function automatic bit busyOf(input int which);
      return (which == 0) ? ifA.busy : ifB.busy;
   endfunction

   task automatic setStart(input int which, input logic v);
      if (which == 0) ifA.start = v; else ifB.start = v;
   endtask

   task automatic setAck(input int which, input logic v);
      if (which == 0) ifA.ack = v; else ifB.ack = v;
   endtask

   // cyc counts clocks with the start-sampling edge as clock 1.
   task automatic runScan(input int which, input bit scr, input bit poke, output int cyc);
      @(negedge clk);
      setStart(which, 1'b1);
      cyc = 0;
      while (1) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == 1) begin
            setStart(which, 1'b0);
            if (scr) scramble();
         end
         if (doneOf(which) || cyc >= 100) break;
         if (poke && cyc == 5) begin setStart(which, 1'b1); setAck(which, 1'b1); end
         if (poke && cyc == 6) begin setStart(which, 1'b0); setAck(which, 1'b0); end
      end
   endtask

   task automatic checkAll(input int which, input string tag);
      int nL, nU, ff, ef, fs, es, ct;
      nL = (which == 0) ? 1 : 2;
      nU = (which == 0) ? 16 : 4;
      for (int l = 0; l < nL; l++) begin
         modelLane(l*nU, nU, ff, ef, fs, es, ct);
         chk($sformatf("%s.ffront%0d", tag, l), getOut(which, l, 0), ff);
         chk($sformatf("%s.efront%0d", tag, l), getOut(which, l, 1), ef);
         chk($sformatf("%s.fsel%0d",   tag, l), getOut(which, l, 2), fs);
         chk($sformatf("%s.esel%0d",   tag, l), getOut(which, l, 3), es);
         chk($sformatf("%s.contact%0d",tag, l), getOut(which, l, 4), ct);
      end
   endtask

   task automatic ackDone(input int which, input string tag);
      @(negedge clk);
      setAck(which, 1'b1);
      @(posedge clk);
      #1;
      setAck(which, 1'b0);
      chk({tag, ".busyAfterAck"}, int'(busyOf(which)), 0);
      chk({tag, ".doneAfterAck"}, int'(doneOf(which)), 0);
   endtask

   task automatic place(input int idx, input int loc, input int typ, input bit enemy);
      if (idx >= 0) begin
         if (enemy) begin eL[idx] = loc; eT[idx] = typ; end
         else       begin fL[idx] = loc; fT[idx] = typ; end
      end
   endtask

   initial begin
      int cyc;
      vecs[0] = '{-1,0,0, -1,0,0,   -1,0,0,    -1,0,0,    511,0,16,16,0};
      vecs[1] = '{14,480,1, -1,0,0, 1,32,1,    -1,0,0,    474,39,14,1,0};
      vecs[2] = '{14,480,1, 2,64,2, 1,32,1,    14,480,2,  58,487,2,14,1};
      vecs[3] = '{0,3,1, -1,0,0,    3,508,1,   -1,0,0,    0,511,0,3,1};
      vecs[4] = '{5,100,1, 9,100,3, -1,0,0,    -1,0,0,    94,0,5,16,0};
      vecs[5] = '{-1,0,0, -1,0,0,   4,200,2,   11,200,1,  511,207,16,4,0};
      vecs[6] = '{7,20,1, -1,0,0,   8,7,1,     -1,0,0,    14,14,7,8,1};
      vecs[7] = '{7,21,1, -1,0,0,   8,7,1,     -1,0,0,    15,14,7,8,0};
      vecs[8] = '{15,511,3, 0,0,0,  0,0,2,     -1,0,0,    505,7,15,0,0};

      ifA.start = 0; ifA.ack = 0; ifB.start = 0; ifB.ack = 0;
      clearUnits();
      driveInputs(0);
      driveInputs(1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("reset.ffront", getOut(0, 0, 0), 511);
      chk("reset.efront", getOut(0, 0, 1), 0);
      chk("reset.fsel",   getOut(0, 0, 2), 16);
      chk("reset.esel",   getOut(0, 0, 3), 16);
      chk("reset.contact",getOut(0, 0, 4), 0);
      chk("reset.busy",   int'(ifA.busy), 0);
      chk("reset.done",   int'(ifA.done), 0);

      for (int i = 0; i < 9; i++) begin
         clearUnits();
         place(vecs[i].fi0, vecs[i].fl0, vecs[i].ft0, 1'b0);
         place(vecs[i].fi1, vecs[i].fl1, vecs[i].ft1, 1'b0);
         place(vecs[i].ei0, vecs[i].el0, vecs[i].et0, 1'b1);
         place(vecs[i].ei1, vecs[i].el1, vecs[i].et1, 1'b1);
         driveInputs(0);
         runScan(0, 1'b0, 1'b0, cyc);
         chk($sformatf("vec%0d.latency", i), cyc, 18);
         chk($sformatf("vec%0d.ffront", i), getOut(0, 0, 0), vecs[i].expFF);
         chk($sformatf("vec%0d.efront", i), getOut(0, 0, 1), vecs[i].expEF);
         chk($sformatf("vec%0d.fsel", i),   getOut(0, 0, 2), vecs[i].expFS);
         chk($sformatf("vec%0d.esel", i),   getOut(0, 0, 3), vecs[i].expES);
         chk($sformatf("vec%0d.contact", i),getOut(0, 0, 4), vecs[i].expC);
         ackDone(0, $sformatf("vec%0d", i));
      end

      // start/ack during SCAN ignored; inputs changed after start ignored
      clearUnits();
      place(14, 480, 1, 1'b0); place(2, 64, 2, 1'b0);
      place(1, 32, 1, 1'b1);   place(14, 480, 2, 1'b1);
      driveInputs(0);
      runScan(0, 1'b1, 1'b1, cyc);
      chk("poke.latency", cyc, 18);
      checkAll(0, "poke");

      // start+ack together in DONE: ack wins, start dropped
      @(negedge clk);
      ifA.start = 1; ifA.ack = 1;
      @(posedge clk);
      #1 ifA.start = 0; ifA.ack = 0;
      chk("startAck.busy", int'(ifA.busy), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("startAck.stayIdle", int'(ifA.busy), 0);
      checkAll(0, "holdIdle");

      // rst during SCAN restores reset values
      driveInputs(0);
      @(negedge clk);
      ifA.start = 1;
      @(posedge clk);
      #1 ifA.start = 0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midRst.ffront", getOut(0, 0, 0), 511);
      chk("midRst.efront", getOut(0, 0, 1), 0);
      chk("midRst.fsel",   getOut(0, 0, 2), 16);
      chk("midRst.esel",   getOut(0, 0, 3), 16);
      chk("midRst.contact",getOut(0, 0, 4), 0);
      chk("midRst.busy",   int'(ifA.busy), 0);
      repeat (20) @(posedge clk);
      #1;
      chk("midRst.doneStaysLow", int'(ifA.done), 0);

      // two lanes of four: lane0 empty, lane1 live
      clearUnits();
      fL[4] = 100; fT[4] = 1; fL[6] = 40; fT[6] = 2;
      eL[5] = 30;  eT[5] = 3; eL[7] = 30; eT[7] = 1;
      driveInputs(1);
      runScan(1, 1'b0, 1'b0, cyc);
      chk("lanes.latency", cyc, 10);
      chk("lanes.l0ffront", getOut(1, 0, 0), 511);
      chk("lanes.l0fsel",   getOut(1, 0, 2), 4);
      chk("lanes.l1ffront", getOut(1, 1, 0), 34);
      chk("lanes.l1fsel",   getOut(1, 1, 2), 2);
      chk("lanes.l1efront", getOut(1, 1, 1), 37);
      chk("lanes.l1esel",   getOut(1, 1, 3), 1);
      chk("lanes.l1contact",getOut(1, 1, 4), 1);
      checkAll(1, "lanes");
      ackDone(1, "lanes");

      for (int it = 0; it < 24; it++) begin
         int which;
         which = (it % 3 == 2) ? 1 : 0;
         clearUnits();
         for (int u = 0; u < 16; u++) begin
            fT[u] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3));
            eT[u] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3));
            fL[u] = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 7)] : int'($urandom_range(0, 511));
            eL[u] = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 7)] : int'($urandom_range(0, 511));
         end
         driveInputs(which);
         runScan(which, 1'b1, 1'b0, cyc);
         chk($sformatf("rnd%0d.latency", it), cyc, (which == 0) ? 18 : 10);
         checkAll(which, $sformatf("rnd%0d", it));
         ackDone(which, $sformatf("rnd%0d", it));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
